// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : psum_accumulator
//  Purpose  : Output-side stage of the conv core. It drains OFIFO rows and
//             accumulates them lane-wise into a NUM_INP x COL psum store over
//             KIJ_LEN kernel passes. ReLU is optional on the final pass. The
//             accumulated rows are then served as a registered readout.
//  Revision : 1.0  initial release
// ============================================================================
module psum_accumulator #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int NUM_INP = 64,
  parameter int KIJ_LEN = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     relu,
  input  logic                     ofifo_valid,
  input  logic [COL*PSUM_BW-1:0]   ofifo_dout,
  output logic                     ofifo_rd,
  input  logic                     psum_rd,
  output logic [COL*PSUM_BW-1:0]   psum_mem_dout,
  output logic                     psum_rd_valid,
  output logic                     acc_done,
  output logic [3:0]               pass_cnt
);

  localparam int ROW_W    = (NUM_INP > 1) ? $clog2(NUM_INP) : 1;
  localparam int ROW_BITS = COL * PSUM_BW;
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_INP - 1);
  localparam logic [3:0]       LAST_PASS = 4'(KIJ_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t               state_q,    state_d;
  logic [ROW_W-1:0]     row_ptr_q,  row_ptr_d;
  logic [ROW_W-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [3:0]           pass_cnt_q, pass_cnt_d;
  logic                 acc_done_q, acc_done_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [ROW_BITS-1:0]  dout_q,     dout_d;

  // Psum store: deliberately not reset, pass 0 overwrites every row.
  logic [ROW_BITS-1:0]  mem [NUM_INP];

  logic                 pop;
  logic                 first_pass;
  logic                 final_pass;
  logic                 issue;
  logic [ROW_BITS-1:0]  acc_row;
  logic [ROW_BITS-1:0]  wr_row;

  assign pop        = (state_q == S_ACCUM) && ofifo_valid;
  assign first_pass = (pass_cnt_q == 4'd0);
  assign final_pass = (pass_cnt_q == LAST_PASS);
  assign acc_row    = mem[row_ptr_q];

  // A readout row is issued for every psum_rd cycle in READ, and in DONE when
  // no restart is requested, so data lands exactly one cycle after the request.
  assign issue = psum_rd && ((state_q == S_READ) || ((state_q == S_DONE) && !start));

  // Per-lane modulo add, with the accumulator forced to zero on the first pass
  // and negative final results clamped when ReLU is requested.
  for (genvar k = 0; k < COL; k++) begin : g_lane
    logic [PSUM_BW-1:0] base;
    logic [PSUM_BW-1:0] sum;
    assign base = first_pass ? '0 : acc_row[k*PSUM_BW +: PSUM_BW];
    assign sum  = base + ofifo_dout[k*PSUM_BW +: PSUM_BW];
    assign wr_row[k*PSUM_BW +: PSUM_BW] =
      (final_pass && relu && sum[PSUM_BW-1]) ? '0 : sum;
  end

  // Single-cycle read-modify-write of the addressed store row on each pop.
  always_ff @(posedge clk) begin
    if (pop) begin
      mem[row_ptr_q] <= wr_row;
    end
  end

  // Next-state, pointer and readout computation.
  always_comb begin
    state_d    = state_q;
    row_ptr_d  = row_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pass_cnt_d = pass_cnt_q;
    acc_done_d = acc_done_q;
    rd_valid_d = 1'b0;
    dout_d     = dout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ACCUM;
          row_ptr_d  = '0;
          pass_cnt_d = 4'd0;
          acc_done_d = 1'b0;
        end
      end
      S_ACCUM: begin
        if (pop) begin
          if (row_ptr_q == LAST_ROW) begin
            row_ptr_d = '0;
            if (final_pass) begin
              pass_cnt_d = 4'd0;
              acc_done_d = 1'b1;
              state_d    = S_DONE;
            end else begin
              pass_cnt_d = pass_cnt_q + 4'd1;
            end
          end else begin
            row_ptr_d = row_ptr_q + ROW_W'(1);
          end
        end
      end
      S_DONE: begin
        if (start) begin
          state_d    = S_ACCUM;
          row_ptr_d  = '0;
          pass_cnt_d = 4'd0;
          acc_done_d = 1'b0;
        end else if (psum_rd) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_READ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      dout_d     = mem[rd_ptr_q];
      rd_valid_d = 1'b1;
      if (rd_ptr_q == LAST_ROW) begin
        rd_ptr_d = '0;
        state_d  = S_DONE;
      end else begin
        rd_ptr_d = rd_ptr_q + ROW_W'(1);
      end
    end
  end

  // State and output registers; reset aborts any operation back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      row_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      pass_cnt_q <= 4'd0;
      acc_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_ptr_q  <= row_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pass_cnt_q <= pass_cnt_d;
      acc_done_q <= acc_done_d;
      rd_valid_q <= rd_valid_d;
      dout_q     <= dout_d;
    end
  end

  assign ofifo_rd      = pop;
  assign psum_mem_dout = dout_q;
  assign psum_rd_valid = rd_valid_q;
  assign acc_done      = acc_done_q;
  assign pass_cnt      = pass_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_psum_accumulator
//  Purpose  : Self-checking bench for psum_accumulator. It uses a queue-based
//             scoreboard fed from an arithmetic reference of the psum sums.
//  Revision : 1.0  initial release
// ============================================================================
module tb_psum_accumulator;

  localparam int COL  = 8;
  localparam int BW   = 16;
  localparam int NI   = 64;
  localparam int KJ   = 9;
  localparam int NPOP = NI * KJ;
  localparam int RW   = COL * BW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          relu = 1'b0;
  logic          ofifo_valid = 1'b0;
  logic [RW-1:0] ofifo_dout = '0;
  logic          ofifo_rd;
  logic          psum_rd = 1'b0;
  logic [RW-1:0] psum_mem_dout;
  logic          psum_rd_valid;
  logic          acc_done;
  logic [3:0]    pass_cnt;

  int tests = 0;
  int fails = 0;
  int rx_cnt = 0;
  int pop_cnt = 0;

  logic [RW-1:0] stream [NPOP];   // OFIFO contents: index pass*NI + row
  logic [RW-1:0] expd   [NI];     // reference result rows
  logic [RW-1:0] got    [NI];     // rows received in the latest readout
  logic [RW-1:0] exp_q  [$];      // scoreboard

  always #5 clk = ~clk;

  psum_accumulator #(.COL(COL), .PSUM_BW(BW), .NUM_INP(NI), .KIJ_LEN(KJ)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .relu          (relu),
    .ofifo_valid   (ofifo_valid),
    .ofifo_dout    (ofifo_dout),
    .ofifo_rd      (ofifo_rd),
    .psum_rd       (psum_rd),
    .psum_mem_dout (psum_mem_dout),
    .psum_rd_valid (psum_rd_valid),
    .acc_done      (acc_done),
    .pass_cnt      (pass_cnt)
  );

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [BW-1:0] lane(input logic [RW-1:0] row, input int k);
    return row[k*BW +: BW];
  endfunction

  // Monitor: counts pops and pops the scoreboard on every valid readout row.
  always @(negedge clk) begin : mon
    logic [RW-1:0] r;
    #2;
    if (!reset) begin
      if (ofifo_rd) begin
        check("ofifo_rd_needs_valid", RW'(ofifo_valid), RW'(1));
        if (ofifo_valid) pop_cnt++;
      end
      if (psum_rd_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_row: got %h expected no row", psum_mem_dout);
        end else begin
          r = exp_q.pop_front();
          check($sformatf("row%0d", rx_cnt), psum_mem_dout, r);
          if (rx_cnt < NI) got[rx_cnt] = psum_mem_dout;
          rx_cnt++;
        end
      end
    end
  end

  // mode 0: random; 1: row 0 holds lane k = k-3 every pass; 2: all 7FFF.
  task automatic fill_stream(input int mode);
    for (int i = 0; i < NPOP; i++) begin
      for (int k = 0; k < COL; k++) begin
        case (mode)
          1:       stream[i][k*BW +: BW] = (i % NI == 0) ? BW'(k - 3) : BW'($urandom);
          2:       stream[i][k*BW +: BW] = 16'h7FFF;
          default: stream[i][k*BW +: BW] = BW'($urandom);
        endcase
      end
    end
  endtask

  // Reference: plain modulo-2^16 sum over all passes, ReLU on the final value.
  task automatic build_model(input bit rl);
    logic [BW-1:0] a;
    for (int r = 0; r < NI; r++) begin
      for (int k = 0; k < COL; k++) begin
        a = '0;
        for (int p = 0; p < KJ; p++) a = a + lane(stream[p*NI + r], k);
        if (rl && a[BW-1]) a = '0;
        expd[r][k*BW +: BW] = a;
      end
    end
  endtask

  task automatic run_conv(input bit rl, input bit bubbles, input int abort_at, input bit start_mid);
    int  idx = 0;
    int  cyc = 0;
    bit  tog = 1'b1;
    bit  took;
    pop_cnt = 0;
    @(negedge clk);
    relu = rl;
    ofifo_valid = 1'b0;
    start = 1'b1;
    while (idx < NPOP && cyc < 4000) begin
      @(negedge clk);
      if (abort_at >= 0 && idx == abort_at) begin
        start = 1'b0;
        ofifo_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_ofifo_rd", RW'(ofifo_rd), '0);
        check("abort_acc_done", RW'(acc_done), '0);
        check("abort_pass_cnt", RW'(pass_cnt), '0);
        check("abort_rd_valid", RW'(psum_rd_valid), '0);
        check("abort_dout", psum_mem_dout, '0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      start = (start_mid && idx >= 100 && idx < 102) ? 1'b1 : 1'b0;
      ofifo_valid = bubbles ? tog : 1'b1;
      tog = ~tog;
      ofifo_dout = stream[idx];
      #1;
      check("ofifo_rd_eq_valid", RW'(ofifo_rd), RW'(ofifo_valid));
      if (ofifo_rd && idx == NPOP - 1) begin
        check("acc_done_before_last", RW'(acc_done), '0);
        check("pass_cnt_before_last", RW'(pass_cnt), RW'(KJ - 1));
      end
      took = ofifo_rd;
      if (took) idx++;
      cyc++;
    end
    @(negedge clk);
    ofifo_valid = 1'b0;
    start = 1'b0;
    check("conv_timeout", RW'(idx), RW'(NPOP));
    check("acc_done_after_last", RW'(acc_done), RW'(1));
    check("pass_cnt_after_last", RW'(pass_cnt), '0);
    #3;
    check("pop_count", RW'(pop_cnt), RW'(NPOP));
  endtask

  task automatic readout(input bit pause);
    int issued = 0;
    int cyc = 0;
    bit prev = 1'b1;
    rx_cnt = 0;
    for (int r = 0; r < NI; r++) exp_q.push_back(expd[r]);
    while (issued < NI && cyc < 1000) begin
      @(negedge clk);
      if (!prev) check("valid_low_in_pause", RW'(psum_rd_valid), '0);
      psum_rd = pause ? ((cyc % 15) < 10) : 1'b1;
      prev = psum_rd;
      if (psum_rd) issued++;
      cyc++;
    end
    @(negedge clk);
    psum_rd = 1'b0;
    repeat (3) @(negedge clk);
    check("rows_received", RW'(rx_cnt), RW'(NI));
    check("scoreboard_empty", RW'(exp_q.size()), '0);
    check("acc_done_after_read", RW'(acc_done), RW'(1));
    check("rd_valid_idle", RW'(psum_rd_valid), '0);
    check("dout_hold", psum_mem_dout, expd[NI-1]);
    exp_q.delete();
  endtask

  initial begin
    logic [RW-1:0] sat_row;
    for (int k = 0; k < COL; k++) sat_row[k*BW +: BW] = 16'h7FF7;

    repeat (2) @(negedge clk);
    check("rst_ofifo_rd", RW'(ofifo_rd), '0);
    check("rst_acc_done", RW'(acc_done), '0);
    check("rst_pass_cnt", RW'(pass_cnt), '0);
    check("rst_rd_valid", RW'(psum_rd_valid), '0);
    check("rst_dout", psum_mem_dout, '0);
    reset = 1'b0;

    // Single-row pattern, no ReLU.
    fill_stream(1);
    run_conv(1'b0, 1'b0, -1, 1'b0);
    build_model(1'b0);
    readout(1'b0);
    check("t1_lane0", RW'(lane(got[0], 0)), RW'(16'hFFE5));
    check("t1_lane7", RW'(lane(got[0], 7)), RW'(16'd36));

    // Same pattern with ReLU.
    fill_stream(1);
    run_conv(1'b1, 1'b0, -1, 1'b0);
    build_model(1'b1);
    readout(1'b0);
    for (int k = 0; k < 4; k++) check($sformatf("t2_lane%0d", k), RW'(lane(got[0], k)), '0);
    check("t2_lane7", RW'(lane(got[0], 7)), RW'(16'd36));

    // Modulo wrap.
    fill_stream(2);
    run_conv(1'b0, 1'b0, -1, 1'b0);
    build_model(1'b0);
    readout(1'b0);
    check("t3_row0", got[0], sat_row);
    check("t3_row63", got[NI-1], sat_row);

    // OFIFO bubbles, then a paused re-read of the same result.
    fill_stream(0);
    run_conv(1'b0, 1'b1, -1, 1'b0);
    build_model(1'b0);
    readout(1'b0);
    readout(1'b1);

    // Reset mid pass 4, then a full run with a stray start pulse.
    fill_stream(0);
    run_conv(1'b0, 1'b0, 4*NI + 10, 1'b0);
    fill_stream(0);
    run_conv(1'b1, 1'b1, -1, 1'b1);
    build_model(1'b1);
    readout(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
